// File: rtl/avalon_st_if.sv
// Avalon-ST stream bundle: data, valid, sop, eop, empty forward; rdy back.
// master drives the beat fields and samples rdy; slave does the reverse.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
    localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

    logic [DW-1:0] data;
    logic          valid;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic          rdy;

    modport master (
        output data, valid, sop, eop, empty,
        input  rdy
    );

    modport slave (
        input  data, valid, sop, eop, empty,
        output rdy
    );
endinterface

// File: rtl/avalon_st_packet_arbiter.sv
// Packet-atomic round-robin merge of NUM_INPUTS Avalon-ST sources onto one sink.
// Ports: clk, rst (async active-low), in_msgs[] slaves, out_msg master,
// grant_idx (locked input), busy (LOCKED), orphan_beat_error (1-cycle pulse).
module avalon_st_packet_arbiter #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int NUM_INPUTS = 4,
    localparam int IW = $clog2(NUM_INPUTS)
) (
    input  logic          clk,
    input  logic          rst,
    avalon_st_if.slave    in_msgs [NUM_INPUTS],
    avalon_st_if.master   out_msg,
    output logic [IW-1:0] grant_idx,
    output logic          busy,
    output logic          orphan_beat_error
);
    localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
    localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state;
    logic [IW-1:0]         rr_ptr;

    logic [DW-1:0]         in_data  [NUM_INPUTS];
    logic [EW-1:0]         in_empty [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] in_valid;
    logic [NUM_INPUTS-1:0] in_sop;
    logic [NUM_INPUTS-1:0] in_eop;
    logic [NUM_INPUTS-1:0] in_rdy;

    // Interface arrays only take constant indices, so flatten them here.
    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_in
        assign in_data[g]    = in_msgs[g].data;
        assign in_empty[g]   = in_msgs[g].empty;
        assign in_valid[g]   = in_msgs[g].valid;
        assign in_sop[g]     = in_msgs[g].sop;
        assign in_eop[g]     = in_msgs[g].eop;
        assign in_msgs[g].rdy = in_rdy[g];
    end

    logic          win_found;
    logic [IW-1:0] win_idx;
    int            j;

    // First sop requester at or after rr_ptr, wrapping modulo NUM_INPUTS.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_INPUTS) j = j - NUM_INPUTS;
            if (!win_found && in_valid[j] && in_sop[j]) begin
                win_found = 1'b1;
                win_idx   = IW'(j);
            end
        end
    end

    logic orphan_hit;
    logic eop_fire;

    assign orphan_hit = |(in_valid & ~in_sop);
    assign eop_fire   = (state == LOCKED) && in_valid[grant_idx]
                      && out_msg.rdy && in_eop[grant_idx];

    always_comb begin
        out_msg.data  = '0;
        out_msg.valid = 1'b0;
        out_msg.sop   = 1'b0;
        out_msg.eop   = 1'b0;
        out_msg.empty = '0;
        if (state == LOCKED) begin
            out_msg.data  = in_data[grant_idx];
            out_msg.valid = in_valid[grant_idx];
            out_msg.sop   = in_sop[grant_idx];
            out_msg.eop   = in_eop[grant_idx];
            out_msg.empty = in_empty[grant_idx];
        end
    end

    // In IDLE, non-sop beats are swallowed; sop beats wait for the grant.
    // rdy is forced low while reset is held so nothing is consumed.
    always_comb begin
        in_rdy = '0;
        if (rst) begin
            if (state == IDLE) in_rdy = in_valid & ~in_sop;
            else               in_rdy[grant_idx] = out_msg.rdy;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            grant_idx         <= '0;
            busy              <= 1'b0;
            orphan_beat_error <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    orphan_beat_error <= orphan_hit;
                    if (win_found) begin
                        state     <= LOCKED;
                        grant_idx <= win_idx;
                        busy      <= 1'b1;
                    end
                end
                LOCKED: begin
                    orphan_beat_error <= 1'b0;
                    if (eop_fire) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        grant_idx <= '0;
                        rr_ptr    <= (grant_idx == IW'(NUM_INPUTS - 1))
                                   ? '0 : grant_idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_st_packet_arbiter.sv
// Scoreboard bench for avalon_st_packet_arbiter: packet-level round-robin
// model pushes expected beats, a monitor pops them off out_msg.
module tb_avalon_st_packet_arbiter;
    typedef struct packed {
        logic [127:0] data;
        logic         sop;
        logic         eop;
        logic [3:0]   empty;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] tdata  [4];
    logic [3:0]   tempty [4];
    logic [3:0]   tvalid;
    logic [3:0]   tsop;
    logic [3:0]   teop;
    wire  [3:0]   trdy;
    logic         o_rdy;
    logic [1:0]   grant_idx;
    logic         busy;
    logic         orphan;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) ins [4] ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) outi ();

    for (genvar g = 0; g < 4; g++) begin : g_drv
        assign ins[g].data  = tdata[g];
        assign ins[g].empty = tempty[g];
        assign ins[g].valid = tvalid[g];
        assign ins[g].sop   = tsop[g];
        assign ins[g].eop   = teop[g];
        assign trdy[g]      = ins[g].rdy;
    end
    assign outi.rdy = o_rdy;

    avalon_st_packet_arbiter #(
        .DATA_WIDTH_IN_BYTES(16),
        .NUM_INPUTS(4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_msgs           (ins),
        .out_msg           (outi),
        .grant_idx         (grant_idx),
        .busy              (busy),
        .orphan_beat_error (orphan)
    );

    beat_t srcq [4][$];
    beat_t expq [$];
    int    sopc [$];
    int    eopc [$];
    int    ordq [$];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   gap_pct = 0;
    int   rdy_pct = 100;
    int   m_owner = -1;
    int   m_ptr   = 0;
    logic m_orph  = 1'b0;

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic add_pkt(int i, int len, bit fixed);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = {$urandom, $urandom, $urandom, $urandom};
            if (fixed) b.data[119:0] = {15{8'd34}};
            b.data[127:120] = 8'(i);
            b.sop   = (k == 0);
            b.eop   = (k == len - 1);
            b.empty = b.eop ? 4'($urandom_range(15)) : 4'd0;
            srcq[i].push_back(b);
        end
    endtask

    task automatic add_orphan(int i);
        beat_t b;
        b.data  = {$urandom, $urandom, $urandom, $urandom};
        b.sop   = 1'b0;
        b.eop   = 1'b0;
        b.empty = 4'd0;
        srcq[i].push_back(b);
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (srcq[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
                tvalid[i] = 1'b1;
                tdata[i]  = srcq[i][0].data;
                tsop[i]   = srcq[i][0].sop;
                teop[i]   = srcq[i][0].eop;
                tempty[i] = srcq[i][0].empty;
            end else begin
                tvalid[i] = 1'b0;
                tdata[i]  = '0;
                tsop[i]   = 1'b0;
                teop[i]   = 1'b0;
                tempty[i] = '0;
            end
        end
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic run_cycles(int n);
        logic [3:0] e;
        logic       nxt_orph;
        int         c;
        bit         done;
        for (int k = 0; k < n; k++) begin
            cyc++;
            drive();
            o_rdy = ($urandom_range(99) < rdy_pct);
            #4;
            for (int i = 0; i < 4; i++) begin
                if (m_owner < 0) e[i] = tvalid[i] & ~tsop[i];
                else             e[i] = (i == m_owner) ? o_rdy : 1'b0;
            end
            chk("in_rdy", trdy, e);
            chk("busy_grant", {busy, grant_idx},
                {m_owner >= 0, (m_owner >= 0) ? 2'(m_owner) : 2'd0});
            chk("orphan_err", orphan, m_orph);
            if (m_owner < 0) chk("idle_out_valid", outi.valid, 1'b0);
            for (int i = 0; i < 4; i++)
                if (tvalid[i] && trdy[i]) void'(srcq[i].pop_front());
            nxt_orph = 1'b0;
            if (m_owner >= 0) begin
                if (tvalid[m_owner] && o_rdy && teop[m_owner]) begin
                    m_ptr   = (m_owner + 1) % 4;
                    m_owner = -1;
                end
            end else begin
                nxt_orph = |(tvalid & ~tsop);
                done = 0;
                for (int jj = 0; jj < 4; jj++) begin
                    c = (m_ptr + jj) % 4;
                    if (!done && tvalid[c] && tsop[c]) begin
                        done    = 1;
                        m_owner = c;
                        for (int b = 0; b < srcq[c].size(); b++) begin
                            expq.push_back(srcq[c][b]);
                            if (srcq[c][b].eop) break;
                        end
                    end
                end
            end
            m_orph = nxt_orph;
            @(negedge clk);
        end
    endtask

    task automatic clear_logs();
        sopc.delete();
        eopc.delete();
        ordq.delete();
    endtask

    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge clk);
            #3;
            if (outi.valid && o_rdy) begin
                if (expq.size() == 0) begin
                    chk("unexpected_beat", {outi.data, outi.sop, outi.eop, outi.empty}, '0);
                end else begin
                    e = expq.pop_front();
                    chk("out_beat", {outi.data, outi.sop, outi.eop, outi.empty}, e);
                end
                if (outi.sop) begin
                    sopc.push_back(cyc);
                    ordq.push_back(int'(outi.data[127:120]));
                end
                if (outi.eop) eopc.push_back(cyc);
            end
        end
    end

    initial begin : stim
        int c0;
        int lim;
        tvalid = '0;
        tsop   = '0;
        teop   = '0;
        o_rdy  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tdata[i]  = '0;
            tempty[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("reset_state", {busy, grant_idx, orphan, outi.valid, trdy}, '0);
        rst = 1'b1;

        // Four 2-beat packets waiting from reset: order 0..3, 11-cycle span.
        clear_logs();
        for (int i = 0; i < 4; i++) add_pkt(i, 2, 0);
        run_cycles(16);
        chk("t2_order", {ordq.size(), ordq[0], ordq[1], ordq[2], ordq[3]},
            {32'd4, 32'd0, 32'd1, 32'd2, 32'd3});
        if (sopc.size() == 4 && eopc.size() == 4)
            chk("t2_span", eopc[3] - sopc[0] + 1, 11);
        else
            chk("t2_pkt_count", {sopc.size(), eopc.size()}, {32'd4, 32'd4});

        // Single 3-beat packet on input 2.
        clear_logs();
        add_pkt(2, 3, 1);
        c0 = cyc + 1;
        run_cycles(6);
        chk("t1_count", {sopc.size(), eopc.size()}, {32'd1, 32'd1});
        chk("t1_sop_latency", sopc[0] - c0, 1);
        chk("t1_eop_cycle", eopc[0] - c0, 3);

        // Input 1 alone moves rr_ptr to 2; then 1 and 3 both request.
        add_pkt(1, 2, 0);
        run_cycles(5);
        clear_logs();
        add_pkt(1, 2, 0);
        add_pkt(3, 3, 0);
        add_pkt(1, 1, 0);
        add_pkt(3, 2, 0);
        run_cycles(16);
        chk("t3_order", {ordq.size(), ordq[0], ordq[1], ordq[2], ordq[3]},
            {32'd4, 32'd3, 32'd1, 32'd3, 32'd1});

        // Two orphan beats on input 0 in IDLE.
        add_orphan(0);
        add_orphan(0);
        run_cycles(4);
        chk("t5_orphans_dropped", srcq[0].size(), 0);

        // Reset in the middle of a 4-beat packet on input 1.
        clear_logs();
        add_pkt(1, 4, 0);
        lim = 0;
        while (srcq[1].size() > 2 && lim < 20) begin
            run_cycles(1);
            lim++;
        end
        chk("t6_reached_beat3", srcq[1].size(), 2);
        drive();
        o_rdy = 1'b1;
        rst   = 1'b0;
        #1;
        chk("t6_reset_out", {busy, grant_idx, orphan, outi.valid, trdy}, '0);
        m_owner = -1;
        m_ptr   = 0;
        m_orph  = 1'b0;
        expq.delete();
        @(negedge clk);
        rst = 1'b1;
        run_cycles(4);
        chk("t6_tail_dropped", srcq[1].size(), 0);
        clear_logs();
        add_pkt(1, 2, 0);
        run_cycles(5);
        chk("t6_regrant", {ordq.size(), ordq[0]}, {32'd1, 32'd1});

        // Random traffic with valid gaps and output backpressure.
        for (int p = 0; p < 30; p++)
            add_pkt($urandom_range(3), $urandom_range(1, 5), 0);
        gap_pct = 20;
        rdy_pct = 60;
        run_cycles(500);
        gap_pct = 0;
        rdy_pct = 100;
        run_cycles(80);
        chk("drain_exp", expq.size(), 0);
        chk("drain_src", srcq[0].size() + srcq[1].size()
                       + srcq[2].size() + srcq[3].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/avalon_st_packet_arbiter.md
# avalon_st_packet_arbiter

Packet-atomic round-robin arbiter that merges `NUM_INPUTS` Avalon-ST sources onto one Avalon-ST sink. A grant is taken on a start-of-packet beat and held until the end-of-packet beat is accepted downstream, so packets are never interleaved. It sits in front of `avalon_enforced` (or any single-stream consumer) when several producers share one datapath.

## Interface
- `DATA_WIDTH_IN_BYTES`, 16, byte width of `data` on all `avalon_st_if` instances
- `NUM_INPUTS`, 4, number of requesters; legal range 2..16
- `clk`  input  1  single clock; all state on rising edge
- `rst`  input  1  asynchronous, active-low reset
- `in_msgs[NUM_INPUTS]`  `avalon_st_if.slave`  array  requester streams (`data`, `valid`, `sop`, `eop`, `empty`, `rdy`)
- `out_msg`  `avalon_st_if.master`  1  merged output stream
- `grant_idx`  output  `$clog2(NUM_INPUTS)`  index of the currently locked input; 0 when idle
- `busy`  output  1  high while state is LOCKED
- `orphan_beat_error`  output  1  one-cycle pulse when a non-sop valid beat is discarded in IDLE

## Operation
- State machine: IDLE, LOCKED.
- IDLE:
  - `out_msg.valid` = 0.
  - Request from input i = `in_msgs[i].valid & in_msgs[i].sop`.
  - Search starts at `rr_ptr` and wraps modulo `NUM_INPUTS`. The first requesting input wins.
  - On a winner: `grant_idx` <= winner and state <= LOCKED. The winner's sop beat is not consumed: `rdy` = 0 to all inputs for sop beats in IDLE.
  - Input i with `valid` = 1 and `sop` = 0: `in_msgs[i].rdy` = 1, so the beat is dropped.
  - `orphan_beat_error` pulses on the next cycle if any input dropped a beat; it is the OR of all inputs.
- LOCKED:
  - `out_msg.{data,valid,sop,eop,empty}` = `in_msgs[grant_idx]` fields, combinational.
  - `in_msgs[grant_idx].rdy` = `out_msg.rdy`.
  - All other inputs: `rdy` = 0, and no orphan detection.
  - When `out_msg.valid & out_msg.rdy & out_msg.eop`: state <= IDLE, `rr_ptr` <= (`grant_idx` + 1) mod `NUM_INPUTS`, `grant_idx` <= 0.
  - A second sop inside a locked packet is forwarded unchanged. Downstream `avalon_enforced` flags it.
- Single-beat packet (sop & eop in the same beat): the packet is accepted in LOCKED and the FSM returns to IDLE after that one beat.
- Backpressure: with `out_msg.rdy` = 0, the arbiter holds LOCKED indefinitely. There is no timeout.
- `rr_ptr` width is `$clog2(NUM_INPUTS)`. Wrap is explicit: for non-power-of-2 `NUM_INPUTS`, the value after `NUM_INPUTS-1` is 0.
- Reset (asserted low, async):
  - state = IDLE, `rr_ptr` = 0, `grant_idx` = 0, `busy` = 0, `orphan_beat_error` = 0.
  - `out_msg.valid` = 0 and all `in_msgs[*].rdy` = 0 while `rst` = 0.
- Reset mid-packet aborts the packet. After release, arbitration restarts from input 0, and the remaining beats of the aborted packet are treated as orphans.

## Timing
- Arbitration latency: sop visible in IDLE at cycle N; grant registered at edge N+1; the sop beat appears on `out_msg` in cycle N+1.
- Datapath latency in LOCKED: 0 cycles (combinational mux). `rdy` is combinational from `out_msg.rdy`.
- Inter-packet bubble: exactly 1 idle cycle between the eop acceptance and the next packet's sop on `out_msg`.
- Sustained throughput: 1 beat/cycle within a packet while `out_msg.rdy` = 1.
- `busy` and `grant_idx` are registered and change on the edge after the grant or eop event.

## Test plan
- Single requester, input 2, sends a 3-beat packet with data 8'd34 repeated, `out_msg.rdy` = 1:
  - sop appears on `out_msg` 1 cycle after being presented; 3 beats out, eop on beat 3; `grant_idx` = 2 while busy; back to IDLE.
- All 4 inputs hold a 2-beat packet from reset:
  - grant order 0, 1, 2, 3; 1 idle cycle between packets; 11 cycles total from the first grant to the last eop.
- Inputs 1 and 3 request continuously with `rr_ptr` = 2:
  - input 3 wins, then 1, then 3; no interleaving of beats from the two inputs.
- Backpressure: `out_msg.rdy` toggles 1,0,0,1 during a 4-beat packet:
  - every beat is delivered exactly once, in order; the non-granted requester sees `rdy` = 0 throughout.
- Input 0 presents valid without sop in IDLE for 2 cycles:
  - both beats are dropped (`rdy` = 1); `orphan_beat_error` pulses on each following cycle; `out_msg.valid` stays 0.
- Reset asserted on beat 2 of a 4-beat packet from input 1:
  - outputs go to reset values immediately; after release, input 1's beats 3–4 are flagged as orphans; input 1's next sop is granted normally.
